// File: rtl/svi_data_sink.sv
// Receive-side sink for the 8-bit interface bus: valid/ready FIFO with registered
// read port, plus accepted-word count, error count and sticky mismatch flag.
module svi_data_sink #(
  parameter int                 DATA_W  = 8,
  parameter int                 DEPTH   = 4,
  parameter logic [DATA_W-1:0]  EXP_VAL = 8'hFF,
  parameter int                 CNT_W   = 16,
  localparam int                AW      = $clog2(DEPTH),
  localparam int                CW      = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_a,
  output logic              o_a_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [CW-1:0]     o_count,
  output logic [CNT_W-1:0]  o_word_cnt,
  output logic [7:0]        o_err_cnt,
  output logic              o_mismatch
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              a_valid_q, a_valid_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              mismatch_q, mismatch_d;

  logic empty, full, push, pop;

  // Flags come only from the registered count, so ready never depends on i_rd_en.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = i_valid && !full;
  assign pop   = i_rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    a_d         = a_q;
    a_valid_d   = 1'b0;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;
    mismatch_d  = mismatch_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (i_data != EXP_VAL) begin
        mismatch_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      a_d       = mem_q[rd_ptr_q];
      a_valid_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      a_q        <= '0;
      a_valid_q  <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      a_q        <= a_d;
      a_valid_q  <= a_valid_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Storage is left uninitialised; a reset only discards it via the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_ready    = !full;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_a        = a_q;
  assign o_a_valid  = a_valid_q;
  assign o_word_cnt = word_cnt_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_mismatch = mismatch_q;

endmodule

// File: tb/tb_svi_data_sink.sv
// Directed bench for svi_data_sink: fill/drain, error statistics, streaming,
// saturation and reset behaviour, each checked against hand-computed values.
module tb_svi_data_sink;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        i_rd_en;
  logic [7:0]  o_a;
  logic        o_a_valid;
  logic        o_empty;
  logic        o_full;
  logic [2:0]  o_count;
  logic [15:0] o_word_cnt;
  logic [7:0]  o_err_cnt;
  logic        o_mismatch;

  int n_vec = 0;
  int n_err = 0;

  svi_data_sink dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .i_rd_en(i_rd_en), .o_a(o_a), .o_a_valid(o_a_valid),
    .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
    .o_word_cnt(o_word_cnt), .o_err_cnt(o_err_cnt), .o_mismatch(o_mismatch)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_rd_en = 1'b0; i_data = 8'h00;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (o_a !== 8'h00) begin n_err++; $display("FAIL reset_a got %h want 00", o_a); end
    n_vec++; if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got %b want 0", o_a_valid); end
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", o_empty); end
    n_vec++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", o_full); end
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_vec++; if (o_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", o_count); end
    n_vec++; if (o_word_cnt !== 16'd0) begin n_err++; $display("FAIL reset_word_cnt got %0d want 0", o_word_cnt); end
    n_vec++; if (o_err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", o_err_cnt); end
    n_vec++; if (o_mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch got %b want 0", o_mismatch); end
  endtask

  task automatic test_fill();
    i_valid = 1'b1; i_data = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (o_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", o_full); end
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", o_ready); end
    n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", o_count); end
    n_vec++; if (o_word_cnt !== 16'd4) begin n_err++; $display("FAIL fill_word_cnt got %0d want 4", o_word_cnt); end
    n_vec++; if (o_err_cnt !== 8'd0) begin n_err++; $display("FAIL fill_err_cnt got %0d want 0", o_err_cnt); end
    tick(); tick();
    n_vec++; if (o_word_cnt !== 16'd4) begin n_err++; $display("FAIL held_off_word_cnt got %0d want 4", o_word_cnt); end
    n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL held_off_count got %0d want 4", o_count); end
  endtask

  // From full: pop and valid together; push must wait a cycle for the freed slot.
  task automatic test_full_pop_push();
    i_valid = 1'b1; i_data = 8'hFF; i_rd_en = 1'b1;
    tick();
    n_vec++; if (o_count !== 3'd3) begin n_err++; $display("FAIL full_pop_count got %0d want 3", o_count); end
    n_vec++; if (o_word_cnt !== 16'd4) begin n_err++; $display("FAIL full_pop_word_cnt got %0d want 4", o_word_cnt); end
    i_rd_en = 1'b0;
    tick();
    i_valid = 1'b0;
    n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL late_push_count got %0d want 4", o_count); end
    n_vec++; if (o_word_cnt !== 16'd5) begin n_err++; $display("FAIL late_push_word_cnt got %0d want 5", o_word_cnt); end
  endtask

  task automatic test_drain();
    i_valid = 1'b0; i_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (o_a !== 8'hFF || o_a_valid !== 1'b1) begin
        n_err++; $display("FAIL drain_%0d got a=%h v=%b want a=ff v=1", i, o_a, o_a_valid);
      end
    end
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", o_empty); end
    tick();
    n_vec++; if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL empty_rd_valid got %b want 0", o_a_valid); end
    n_vec++; if (o_a !== 8'hFF) begin n_err++; $display("FAIL empty_rd_hold got %h want ff", o_a); end
    i_rd_en = 1'b0;
  endtask

  task automatic test_mismatch();
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h80;
    apply_reset();
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin i_data = words[i]; tick(); end
    i_valid = 1'b0;
    n_vec++; if (o_err_cnt !== 8'd2) begin n_err++; $display("FAIL mm_err_cnt got %0d want 2", o_err_cnt); end
    n_vec++; if (o_mismatch !== 1'b1) begin n_err++; $display("FAIL mm_flag got %b want 1", o_mismatch); end
    n_vec++; if (o_word_cnt !== 16'd3) begin n_err++; $display("FAIL mm_word_cnt got %0d want 3", o_word_cnt); end
    i_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (o_a !== words[i] || o_a_valid !== 1'b1) begin
        n_err++; $display("FAIL mm_pop_%0d got a=%h v=%b want a=%h v=1", i, o_a, o_a_valid, words[i]);
      end
    end
    i_rd_en = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    i_valid = 1'b1;
    i_data = 8'hA0; tick();
    i_data = 8'hA1; tick();
    i_rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_data = 8'hA2 + 8'(k);
      tick();
      n_vec++; if (o_count !== 3'd2) begin n_err++; $display("FAIL stream_count_%0d got %0d want 2", k, o_count); end
      n_vec++; if (o_a !== 8'hA0 + 8'(k) || o_a_valid !== 1'b1) begin
        n_err++; $display("FAIL stream_data_%0d got a=%h v=%b want a=%h v=1", k, o_a, o_a_valid, 8'hA0 + 8'(k));
      end
    end
    i_valid = 1'b0; i_rd_en = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    i_valid = 1'b1; i_data = 8'h00; i_rd_en = 1'b1;
    tick();
    n_vec++; if (o_count !== 3'd1) begin n_err++; $display("FAIL empty_pushpop_count got %0d want 1", o_count); end
    n_vec++; if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL empty_pushpop_valid got %b want 0", o_a_valid); end
    for (int i = 1; i < 300; i++) tick();
    i_valid = 1'b0; i_rd_en = 1'b0;
    n_vec++; if (o_err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_err_cnt got %0d want 255", o_err_cnt); end
    n_vec++; if (o_word_cnt !== 16'd300) begin n_err++; $display("FAIL sat_word_cnt got %0d want 300", o_word_cnt); end
    n_vec++; if (o_mismatch !== 1'b1) begin n_err++; $display("FAIL sat_flag got %b want 1", o_mismatch); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_vec++; if (o_err_cnt !== 8'd0) begin n_err++; $display("FAIL sat_rst_err_cnt got %0d want 0", o_err_cnt); end
    n_vec++; if (o_mismatch !== 1'b0) begin n_err++; $display("FAIL sat_rst_flag got %b want 0", o_mismatch); end
    n_vec++; if (o_word_cnt !== 16'd0) begin n_err++; $display("FAIL sat_rst_word_cnt got %0d want 0", o_word_cnt); end
    n_vec++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_ready !== 1'b1 || o_full !== 1'b0) begin
      n_err++; $display("FAIL sat_rst_flags got c=%0d e=%b r=%b f=%b want c=0 e=1 r=1 f=0", o_count, o_empty, o_ready, o_full);
    end
    n_vec++; if (o_a !== 8'h00 || o_a_valid !== 1'b0) begin
      n_err++; $display("FAIL sat_rst_a got a=%h v=%b want a=00 v=0", o_a, o_a_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_valid = 1'b1; i_data = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (o_count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count got %0d want 3", o_count); end
    i_rst = 1'b1; i_valid = 1'b1; i_rd_en = 1'b1; i_data = 8'h55;
    tick();
    i_rst = 1'b0; i_valid = 1'b0; i_rd_en = 1'b0;
    n_vec++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", o_count); end
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", o_empty); end
    n_vec++; if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL mid_a_valid got %b want 0", o_a_valid); end
    n_vec++; if (o_word_cnt !== 16'd0) begin n_err++; $display("FAIL mid_word_cnt got %0d want 0", o_word_cnt); end
    tick();
    n_vec++; if (o_count !== 3'd0 || o_word_cnt !== 16'd0) begin
      n_err++; $display("FAIL mid_after got c=%0d w=%0d want c=0 w=0", o_count, o_word_cnt);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_rd_en = 1'b0; i_data = 8'h00;
    test_reset();
    test_fill();
    test_full_pop_push();
    test_drain();
    test_mismatch();
    test_stream();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/svi_data_sink.md
# svi_data_sink

Consumer end of the 8-bit interface data bus. It accepts words from an upstream interface driver over a valid/ready handshake and buffers them in a small FIFO. Software-visible logic drains the FIFO one word per read strobe. On acceptance, each word is checked against an expected constant, and the block keeps a word count and an error count. It sits in `top` on the receive side of the `u_I` interface instance and replaces the direct wire-through from `u_I.data` to `o_a`.

## Interface
Parameters:
- DATA_W, 8, data word width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- EXP_VAL, 8'hFF, expected value of every accepted word
- CNT_W, 16, width of accepted-word counter

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  upstream word valid
- i_data  in  DATA_W  upstream word
- o_ready  out  1  sink can accept; equals !o_full
- i_rd_en  in  1  read strobe (pop request)
- o_a  out  DATA_W  registered read data
- o_a_valid  out  1  o_a holds a freshly popped word (one-cycle pulse)
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_count  out  log2(DEPTH)+1  current occupancy
- o_word_cnt  out  CNT_W  total accepted words, wraps modulo 2^CNT_W
- o_err_cnt  out  8  accepted words != EXP_VAL, saturates at 255
- o_mismatch  out  1  sticky flag, set on first mismatch

## Operation
- Storage: DEPTH×DATA_W register array, write pointer and read pointer of log2(DEPTH) bits each, plus an occupancy counter. Pointers wrap from DEPTH-1 to 0.
- Accept (push): i_valid && o_ready at a rising edge. The block writes i_data at wr_ptr, increments wr_ptr, and increments o_word_cnt.
- Compare: on every accept, i_data != EXP_VAL increments o_err_cnt (holding at 255) and sets o_mismatch. o_mismatch clears only on reset.
- Pop: i_rd_en && !o_empty. The block loads o_a from mem[rd_ptr], increments rd_ptr, and pulses o_a_valid high for one cycle.
- i_rd_en while empty is ignored: no pointer change, o_a_valid=0, o_a holds its previous value.
- i_valid while full is not accepted. Upstream must hold the word until o_ready=1. The block does not count the word or compare it.
- Simultaneous push and pop when 0<count<DEPTH: both occur and o_count is unchanged.
- When full, o_ready=0 even if i_rd_en is high in the same cycle. There is no same-cycle bypass, so the push lands one cycle after the pop frees a slot.
- When empty, a push and a pop request in the same cycle: the pop is ignored and the push occurs, so count goes to 1. There is no write-through.
- o_empty = (count==0); o_full = (count==DEPTH); o_ready = !o_full. All three derive from registered count, so there is no combinational path from i_valid or i_rd_en.
- Reset mid-operation: all pointers, count and statistics clear at the next edge. FIFO contents are discarded. Memory contents need not be cleared.

## Timing
- Reset values: o_a=0, o_a_valid=0, o_empty=1, o_full=0, o_ready=1, o_count=0, o_word_cnt=0, o_err_cnt=0, o_mismatch=0.
- Push latency:
  - o_count, o_empty and o_full update the cycle after the accepting edge.
  - A word accepted at edge N can be popped by a read at edge N+1.
  - Its data appears on o_a after edge N+1, with o_a_valid high for that cycle.
- Pop latency: o_a and o_a_valid are registered, so data is valid the cycle following the i_rd_en edge.
- Statistics: o_word_cnt, o_err_cnt and o_mismatch update one cycle after the accepting edge.
- Throughput: one push and one pop per cycle sustained while 0<count<DEPTH.

## Test plan
- Reset, then 4 pushes of 8'hFF with no reads → o_full=1, o_ready=0, o_count=4, o_word_cnt=4, o_err_cnt=0. A 5th i_valid is held off, and o_word_cnt stays 4.
- From full, 4 consecutive i_rd_en → o_a reads FF,FF,FF,FF with o_a_valid high for 4 cycles, then o_empty=1. A further i_rd_en gives o_a_valid=0 and o_a unchanged.
- Push 8'h01, 8'hFF, 8'h80 → o_err_cnt=2, o_mismatch=1, o_word_cnt=3. Pops return 01, FF, 80 in order.
- Streaming at count=2 with push and pop every cycle for 10 cycles → o_count stays 2, data order preserved, pointers wrap past DEPTH-1 cleanly.
- 300 mismatching pushes (drained concurrently) → o_err_cnt=255, saturated. Assert i_rst → all outputs return to reset values one cycle later, and o_mismatch=0.
- Fill to 3 entries, assert i_rst together with i_valid and i_rd_en → the next cycle shows o_count=0, o_empty=1, o_a_valid=0, and no word accepted.
